// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: RV32I load/store
// funct3 encodings, the LSU state enum and store lane helpers.
// Optional build macro used by the LSU: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_WAIT_RD  = 2'd2
  } lsu_state_e;

  // Byte enables for a store; unknown funct3 behaves as a full word.
  function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic [3:0] be;
    case (funct3)
      F3_SB:   be = 4'b0001 << off;
      F3_SH:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane the access could hit.
  function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                              input logic [31:0] rs2);
    logic [31:0] wd;
    case (funct3)
      F3_SB:   wd = {4{rs2[7:0]}};
      F3_SH:   wd = {2{rs2[15:0]}};
      default: wd = rs2;
    endcase
    return wd;
  endfunction

  // Misaligned when the offset is not a multiple of the access size.
  // Byte accesses never misalign; unknown funct3 is sized as a word.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic m;
    case (funct3)
      F3_LB, F3_LBU: m = 1'b0;
      F3_LH, F3_LHU: m = off[0];
      default:       m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of the read word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane selection followed by extension; unknown funct3 passes the word.
  always_comb begin
    byte_v = rdata[7:0];
    case (off)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_v[7]}}, byte_v};
      F3_LH:   data = {{16{half_v[15]}}, half_v};
      F3_LBU:  data = {24'd0, byte_v};
      F3_LHU:  data = {16'd0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Issues one data-memory access at a time
// over req/gnt/rvalid, aligns load data and drives the MEM/WB write port.
// Handshake: a request is accepted in the cycle dmem_req_o and dmem_gnt_i
// are both high; request fields stay stable from first assertion until
// that cycle. Read data is taken in a later cycle with dmem_rvalid_i high.
// Build option LSU_MISALIGN_TRAP_EN: misaligned accesses are refused and
// reported on misalign_o instead of being aligned down.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  input  logic              ex_is_load_i,
  input  logic              ex_is_store_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [DATA_W-1:0] ex_alu_result_i,
  input  logic [DATA_W-1:0] ex_store_data_i,
  input  logic [4:0]        ex_rd_addr_i,
  input  logic              ex_rd_wren_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              rd_wren_o,
  output logic [4:0]        rd_addr_o,
  output logic [DATA_W-1:0] wb_data_o
);

  lsu_state_e        state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_q;
  logic              wren_q;

  logic              is_mem;
  logic              mis;
  logic              mem_go;
  logic [ADDR_W-1:0] ex_addr_word;
  logic [3:0]        ex_be;
  logic [DATA_W-1:0] ex_wdata;
  logic [DATA_W-1:0] load_data;

  assign is_mem       = ex_valid_i & (ex_is_load_i | ex_is_store_i);
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis          = is_mem & is_misaligned(ex_funct3_i, ex_alu_result_i[1:0]);
`else
  assign mis          = 1'b0;
`endif
  assign mem_go       = is_mem & ~mis;
  assign ex_addr_word = {ex_alu_result_i[ADDR_W-1:2], 2'b00};
  assign ex_be        = ex_is_store_i ? store_be(ex_funct3_i, ex_alu_result_i[1:0])
                                      : 4'b1111;
  assign ex_wdata     = ex_is_store_i ? store_wdata(ex_funct3_i, ex_store_data_i)
                                      : '0;

  lsu_load_align u_align (
    .rdata  (dmem_rdata_i),
    .off    (off_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // Access sequencing and request-field capture on leaving IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      rd_q     <= 5'd0;
      wren_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_go) begin
            we_q     <= ex_is_store_i;
            addr_q   <= ex_addr_word;
            be_q     <= ex_be;
            wdata_q  <= ex_wdata;
            funct3_q <= ex_funct3_i;
            off_q    <= ex_alu_result_i[1:0];
            rd_q     <= ex_rd_addr_i;
            wren_q   <= ex_rd_wren_i;
            if (!dmem_gnt_i)        state_q <= ST_WAIT_GNT;
            else if (!ex_is_store_i) state_q <= ST_WAIT_RD;
          end
        end
        ST_WAIT_GNT: begin
          if (dmem_gnt_i) state_q <= we_q ? ST_IDLE : ST_WAIT_RD;
        end
        ST_WAIT_RD: begin
          if (dmem_rvalid_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output decode: pass-through in IDLE, held request while waiting for
  // grant, load writeback on rvalid; everything forced low under reset.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = '0;
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    rd_wren_o    = 1'b0;
    rd_addr_o    = 5'd0;
    wb_data_o    = '0;
    if (!rst_i) begin
      case (state_q)
        ST_IDLE: begin
          if (mem_go) begin
            dmem_req_o   = 1'b1;
            dmem_we_o    = ex_is_store_i;
            dmem_addr_o  = ex_addr_word;
            dmem_be_o    = ex_be;
            dmem_wdata_o = ex_wdata;
            stall_o      = ~(ex_is_store_i & dmem_gnt_i);
          end else if (mis) begin
            misalign_o = 1'b1;
          end else begin
            wb_data_o = ex_alu_result_i;
            rd_addr_o = ex_rd_addr_i;
            rd_wren_o = ex_valid_i & ex_rd_wren_i & (ex_rd_addr_i != 5'd0);
          end
        end
        ST_WAIT_GNT: begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = we_q;
          dmem_addr_o  = addr_q;
          dmem_be_o    = be_q;
          dmem_wdata_o = wdata_q;
          stall_o      = ~(dmem_gnt_i & we_q);
        end
        ST_WAIT_RD: begin
          if (dmem_rvalid_i) begin
            wb_data_o = load_data;
            rd_addr_o = rd_q;
            rd_wren_o = wren_q & (rd_q != 5'd0);
          end else begin
            stall_o = 1'b1;
          end
        end
        default: stall_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: reset, ALU pass-through, store lanes,
// delayed grant/rvalid loads, load extension, reset mid-access, misalign.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_is_load, ex_is_store, ex_rd_wren;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu, ex_sdata;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, misalign, rd_wren;
  logic [4:0]  rd_addr;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_is_load_i(ex_is_load), .ex_is_store_i(ex_is_store),
    .ex_funct3_i(ex_funct3), .ex_alu_result_i(ex_alu), .ex_store_data_i(ex_sdata),
    .ex_rd_addr_i(ex_rd), .ex_rd_wren_i(ex_rd_wren),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .stall_o(stall), .misalign_o(misalign), .rd_wren_o(rd_wren),
    .rd_addr_o(rd_addr), .wb_data_o(wb_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_rd_wren = 0;
    ex_funct3 = 3'b000; ex_alu = 32'h0; ex_sdata = 32'h0; ex_rd = 5'd0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 32'h0;
  endtask

  task automatic drive_mem(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [4:0] rd);
    ex_valid = 1; ex_is_load = ~st; ex_is_store = st; ex_rd_wren = ~st;
    ex_funct3 = f3; ex_alu = a; ex_sdata = sd; ex_rd = rd;
  endtask

  task automatic test_reset();
    rst = 1;
    drive_mem(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd3);
    dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    #1;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall, misalign,
         rd_wren, rd_addr, wb_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: req=%b addr=%h be=%b stall=%b wren=%b wb=%h required all 0",
               dmem_req, dmem_addr, dmem_be, stall, rd_wren, wb_data);
    end
    idle_inputs();
    rst = 0;
    tick();
  endtask

  task automatic test_alu_pass();
    ex_valid = 1; ex_rd_wren = 1; ex_rd = 5'd5; ex_alu = 32'h1234;
    #1;
    total++;
    if ({rd_wren, rd_addr, wb_data, stall, dmem_req} !== {1'b1, 5'd5, 32'h1234, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL add_pass: wren=%b rd=%0d wb=%h stall=%b req=%b required 1 5 00001234 0 0",
               rd_wren, rd_addr, wb_data, stall, dmem_req);
    end
    ex_rd = 5'd0;
    #1;
    total++;
    if (rd_wren !== 1'b0) begin
      bad++; $display("FAIL add_x0_wren: got %b required 0", rd_wren);
    end
    ex_rd = 5'd9; ex_valid = 0;
    #1;
    total++;
    if (rd_wren !== 1'b0) begin
      bad++; $display("FAIL invalid_wren: got %b required 0", rd_wren);
    end
    tick();
    idle_inputs();
  endtask

  // store accepted in the same cycle; checks lanes and that no stall occurs
  task automatic store_now(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd);
    drive_mem(1'b1, f3, a, sd, 5'd4);
    dmem_gnt = 1;
    #1;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall, rd_wren} !==
        {1'b1, 1'b1, exp_addr, exp_be, exp_wd, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL %s: req=%b we=%b addr=%h be=%b wd=%h stall=%b wren=%b required 1 1 %h %b %h 0 0",
               nm, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall, rd_wren,
               exp_addr, exp_be, exp_wd);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if ({dmem_req, stall} !== 2'b00) begin
      bad++; $display("FAIL %s_after: req=%b stall=%b required 0 0", nm, dmem_req, stall);
    end
  endtask

  task automatic test_stores();
    store_now("sb_103", 3'b000, 32'h103, 32'h0000_00AB, 32'h100, 4'b1000, 32'hABAB_ABAB);
    store_now("sh_102", 3'b001, 32'h102, 32'h1234_CDEF, 32'h100, 4'b1100, 32'hCDEF_CDEF);
    store_now("sw_200", 3'b010, 32'h200, 32'h1122_3344, 32'h200, 4'b1111, 32'h1122_3344);
  endtask

  task automatic test_store_wait_gnt();
    drive_mem(1'b1, 3'b010, 32'h300, 32'h5566_7788, 5'd0);
    #1;
    total++;
    if ({dmem_req, stall} !== 2'b11) begin
      bad++; $display("FAIL sw_nogrant: req=%b stall=%b required 1 1", dmem_req, stall);
    end
    tick();
    ex_alu = 32'hDEAD_BEE0; ex_sdata = 32'h0;
    dmem_gnt = 1;
    #1;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall} !==
        {1'b1, 1'b1, 32'h300, 32'h5566_7788, 4'b1111, 1'b0}) begin
      bad++;
      $display("FAIL sw_grant: req=%b we=%b addr=%h wd=%h be=%b stall=%b required 1 1 300 55667788 1111 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_lb_delayed();
    int stable_ok;
    int stall_ok;
    stable_ok = 0;
    stall_ok = 0;
    drive_mem(1'b0, 3'b000, 32'h101, 32'h0, 5'd7);
    for (int c = 0; c < 3; c++) begin
      dmem_gnt = (c == 2);
      #1;
      if (dmem_req === 1'b1 && dmem_we === 1'b0 && dmem_addr === 32'h100 &&
          dmem_be === 4'b1111) stable_ok++;
      if (stall === 1'b1 && rd_wren === 1'b0) stall_ok++;
      tick();
      ex_alu = 32'h0000_0F0C;
    end
    dmem_gnt = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (dmem_req === 1'b0) stable_ok++;
      if (stall === 1'b1 && rd_wren === 1'b0) stall_ok++;
      tick();
    end
    total++;
    if (stable_ok !== 5) begin
      bad++; $display("FAIL lb_req_hold: good_cycles=%0d required 5", stable_ok);
    end
    total++;
    if (stall_ok !== 5) begin
      bad++; $display("FAIL lb_stall: good_cycles=%0d required 5", stall_ok);
    end
    dmem_rvalid = 1; dmem_rdata = 32'h00F0_8000;
    #1;
    total++;
    if ({stall, rd_wren, rd_addr, wb_data} !== {1'b0, 1'b1, 5'd7, 32'hFFFF_FF80}) begin
      bad++;
      $display("FAIL lb_result: stall=%b wren=%b rd=%0d wb=%h required 0 1 7 ffffff80",
               stall, rd_wren, rd_addr, wb_data);
    end
    tick();
    idle_inputs();
  endtask

  // load granted at once, rvalid in the following cycle
  task automatic load_now(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic exp_wren, input logic [31:0] exp_wb);
    drive_mem(1'b0, f3, a, 32'h0, rd);
    dmem_gnt = 1;
    #1;
    total++;
    if ({dmem_req, dmem_we, dmem_be, stall} !== {1'b1, 1'b0, 4'b1111, 1'b1}) begin
      bad++;
      $display("FAIL %s_req: req=%b we=%b be=%b stall=%b required 1 0 1111 1",
               nm, dmem_req, dmem_we, dmem_be, stall);
    end
    tick();
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = rdata;
    #1;
    total++;
    if ({stall, rd_wren, wb_data} !== {1'b0, exp_wren, exp_wb}) begin
      bad++;
      $display("FAIL %s: stall=%b wren=%b wb=%h required 0 %b %h",
               nm, stall, rd_wren, wb_data, exp_wren, exp_wb);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_load_extend();
    load_now("lhu_202", 3'b101, 32'h202, 5'd6, 32'h8001_0000, 1'b1, 32'h0000_8001);
    load_now("lh_202",  3'b001, 32'h202, 5'd6, 32'h8001_0000, 1'b1, 32'hFFFF_8001);
    load_now("lbu_103", 3'b100, 32'h103, 5'd8, 32'h9A00_0000, 1'b1, 32'h0000_009A);
    load_now("lw_x0",   3'b010, 32'h400, 5'd0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_mid();
    drive_mem(1'b0, 3'b010, 32'h500, 32'h0, 5'd10);
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    rst = 1;
    #1;
    total++;
    if ({dmem_req, stall, rd_wren, rd_addr, wb_data} !== '0) begin
      bad++;
      $display("FAIL rst_mid: req=%b stall=%b wren=%b rd=%0d wb=%h required all 0",
               dmem_req, stall, rd_wren, rd_addr, wb_data);
    end
    tick();
    rst = 0;
    idle_inputs();
    dmem_rvalid = 1; dmem_rdata = 32'h1357_9BDF;
    #1;
    total++;
    if ({dmem_req, stall, rd_wren, wb_data} !== '0) begin
      bad++;
      $display("FAIL rst_rvalid_ignored: req=%b stall=%b wren=%b wb=%h required all 0",
               dmem_req, stall, rd_wren, wb_data);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_misalign();
    drive_mem(1'b0, 3'b010, 32'h106, 32'h0, 5'd11);
    dmem_gnt = 1;
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    total++;
    if ({misalign, dmem_req, stall, rd_wren} !== 4'b1000) begin
      bad++;
      $display("FAIL lw_misalign_trap: mis=%b req=%b stall=%b wren=%b required 1 0 0 0",
               misalign, dmem_req, stall, rd_wren);
    end
    tick();
    idle_inputs();
`else
    total++;
    if ({misalign, dmem_req, dmem_addr, dmem_be} !== {1'b0, 1'b1, 32'h104, 4'b1111}) begin
      bad++;
      $display("FAIL lw_misalign_aligned: mis=%b req=%b addr=%h be=%b required 0 1 104 1111",
               misalign, dmem_req, dmem_addr, dmem_be);
    end
    tick();
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h2468_ACE0;
    #1;
    total++;
    if ({rd_wren, wb_data} !== {1'b1, 32'h2468_ACE0}) begin
      bad++;
      $display("FAIL lw_misalign_data: wren=%b wb=%h required 1 2468ace0", rd_wren, wb_data);
    end
    tick();
    idle_inputs();
`endif
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_alu_pass();
    test_stores();
    test_store_wait_gnt();
    test_lb_delayed();
    test_load_extend();
    test_reset_mid();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
